// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read-side subordinates: response codes,
// burst encodings, supported beat size and the read FSM state type.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    // Only full 32-bit beats are served.
    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } rd_state_t;

endpackage

// File: rtl/axi_burst_addr_next.sv
// Next beat address for an AXI burst of 32-bit beats. Purely combinational
// so any subordinate can step its address on a data handshake.
module axi_burst_addr_next
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] addr_next
);

    logic [31:0] addr_inc;
    logic [31:0] wrap_mask;

    assign addr_inc  = addr + 32'd4;
    // Wrap span is (len+1) beats of 4 bytes; the mask keeps the offset inside it.
    assign wrap_mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;

    // Select the stepping rule for the burst type; reserved types hold the address.
    always_comb begin
        addr_next = addr;
        case (burst)
            BURST_INCR: addr_next = addr_inc;
            BURST_WRAP: addr_next = (addr & ~wrap_mask) | (addr_inc & wrap_mask);
            default:    addr_next = addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-only subordinate backing the instruction-fetch refill port.
// One outstanding burst, programmable first-beat latency, word store
// preloaded through a simple write port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ar_ready high, waiting for a read address
// WAIT  | address latched, latency down-counter running to 1
// BURST | r_valid high, presenting registered beats until the last one
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter int          ID_W        = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ar_valid,
    output logic            ar_ready,
    input  logic [31:0]     ar_addr,
    input  logic [ID_W-1:0] ar_id,
    input  logic [7:0]      ar_len,
    input  logic [2:0]      ar_size,
    input  logic [1:0]      ar_burst,
    output logic            r_valid,
    input  logic            r_ready,
    output logic [31:0]     r_data,
    output logic [1:0]      r_resp,
    output logic            r_last,
    output logic [ID_W-1:0] r_id,
    input  logic            wr_en,
    input  logic [31:0]     wr_addr,
    input  logic [31:0]     wr_data
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) * 32'd4;

    rd_state_t state, state_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [1:0]  burst_q;
    logic        err_q;
    logic [7:0]  beat_cnt;
    logic [3:0]  lat_cnt;
    logic [31:0] addr_nxt;

    logic        ar_hs;
    logic        r_hs;
    logic        wrap_len_ok;
    logic        ar_err;

    logic        load_beat;
    logic [31:0] ld_addr;
    logic        ld_err;
    logic        ld_last;
    logic [31:0] ld_off;
    logic        ld_ok;
    logic [31:0] wr_off;

    assign ar_hs   = ar_valid && ar_ready;
    assign r_valid = (state == BURST);
    assign r_hs    = r_valid && r_ready;

    // Whole-burst errors are decided once at acceptance and carried in err_q.
    assign wrap_len_ok = (ar_len == 8'd1) || (ar_len == 8'd3) ||
                         (ar_len == 8'd7) || (ar_len == 8'd15);
    assign ar_err = (ar_size != SIZE_WORD) || (ar_burst == BURST_RSVD) ||
                    ((ar_burst == BURST_WRAP) && !wrap_len_ok);

    // Unsigned offset from the base; addresses below the base wrap to huge values.
    assign ld_off = ld_addr - BASE_ADDR;
    assign ld_ok  = !ld_err && (ld_off < SPAN_BYTES);
    assign wr_off = wr_addr - BASE_ADDR;

    axi_burst_addr_next u_addr_next (
        .addr      (addr_q),
        .len       (len_q),
        .burst     (burst_q),
        .addr_next (addr_nxt)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the beat-load strobe and the address/last flag it uses.
    always_comb begin
        state_nxt = state;
        load_beat = 1'b0;
        ld_addr   = addr_q;
        ld_err    = err_q;
        ld_last   = 1'b0;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    if (LATENCY == 0) begin
                        state_nxt = BURST;
                        load_beat = 1'b1;
                        ld_addr   = ar_addr;
                        ld_err    = ar_err;
                        ld_last   = (ar_len == 8'd0);
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == 4'd1) begin
                    state_nxt = BURST;
                    load_beat = 1'b1;
                    ld_last   = (len_q == 8'd0);
                end
            end
            BURST: begin
                if (r_hs) begin
                    if (r_last) begin
                        state_nxt = IDLE;
                    end else begin
                        load_beat = 1'b1;
                        ld_addr   = addr_nxt;
                        ld_last   = ((beat_cnt + 8'd1) == len_q);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, latency timer, beat sequencing and registered R outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ar_ready <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= BURST_FIXED;
            err_q    <= 1'b0;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
            r_last   <= 1'b0;
            r_id     <= '0;
        end else begin
            ar_ready <= (state_nxt == IDLE);
            if (ar_hs) begin
                addr_q   <= ar_addr;
                len_q    <= ar_len;
                burst_q  <= ar_burst;
                err_q    <= ar_err;
                r_id     <= ar_id;
                beat_cnt <= '0;
                lat_cnt  <= 4'(LATENCY);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (r_hs && !r_last) begin
                addr_q   <= addr_nxt;
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (load_beat) begin
                r_data <= ld_ok ? mem[ld_off[IDX_W+1:2]] : '0;
                r_resp <= ld_ok ? RESP_OKAY : RESP_SLVERR;
                r_last <= ld_last;
            end
        end
    end

    // Preload port; contents survive reset and out-of-range writes are dropped.
    always_ff @(posedge clock) begin
        if (wr_en && (wr_off < SPAN_BYTES)) begin
            mem[wr_off[IDX_W+1:2]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: directed scenarios plus randomized bursts,
// each checked against a beat-list model of the store and burst rules.
module tb_axi_rd_responder;
    import axi_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;
    localparam int          IDW   = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           ar_valid = 1'b0;
    logic           ar_ready;
    logic [31:0]    ar_addr = '0;
    logic [IDW-1:0] ar_id = '0;
    logic [7:0]     ar_len = '0;
    logic [2:0]     ar_size = '0;
    logic [1:0]     ar_burst = '0;
    logic           r_valid;
    logic           r_ready = 1'b0;
    logic [31:0]    r_data;
    logic [1:0]     r_resp;
    logic           r_last;
    logic [IDW-1:0] r_id;
    logic           wr_en = 1'b0;
    logic [31:0]    wr_addr = '0;
    logic [31:0]    wr_data = '0;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0]    mem_m [DEPTH];
    logic [31:0]    exp_a [$];
    logic [31:0]    exp_d [$];
    logic [1:0]     exp_r [$];
    logic [IDW-1:0] exp_id;
    logic [7:0]     exp_len;

    logic [31:0]    nxt_addr;
    logic [IDW-1:0] nxt_id;
    logic [7:0]     nxt_len;
    logic [1:0]     nxt_burst;
    logic [2:0]     nxt_size;

    always #5 clock = ~clock;

    axi_rd_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .ID_W        (IDW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ar_valid (ar_valid),
        .ar_ready (ar_ready),
        .ar_addr  (ar_addr),
        .ar_id    (ar_id),
        .ar_len   (ar_len),
        .ar_size  (ar_size),
        .ar_burst (ar_burst),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_data   (r_data),
        .r_resp   (r_resp),
        .r_last   (r_last),
        .r_id     (r_id),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit in_store(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) &&
               (longint'(a) < longint'(BASE) + longint'(DEPTH) * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) >> 2);
    endfunction

    // Address of beat i, computed directly from the first address.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] bst, input int i);
        longint span, lo, off;
        case (bst)
            BURST_INCR: return a + 32'(4 * i);
            BURST_WRAP: begin
                span = (longint'(len) + 1) * 4;
                lo   = longint'(a) - (longint'(a) % span);
                off  = (longint'(a) - lo + 4 * i) % span;
                return 32'(lo + off);
            end
            default: return a;
        endcase
    endfunction

    task automatic model_txn(input logic [31:0] a, input logic [IDW-1:0] id, input logic [7:0] len,
                             input logic [1:0] bst, input logic [2:0] sz);
        bit bad;
        logic [31:0] ba;
        exp_a.delete();
        exp_d.delete();
        exp_r.delete();
        exp_id  = id;
        exp_len = len;
        bad = (sz != 3'd2) || (bst == 2'd3) ||
              ((bst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        for (int i = 0; i <= int'(len); i++) begin
            ba = beat_addr(a, len, bst, i);
            exp_a.push_back(ba);
            if (!bad && in_store(ba)) begin
                exp_d.push_back(mem_m[widx(ba)]);
                exp_r.push_back(RESP_OKAY);
            end else begin
                exp_d.push_back(32'd0);
                exp_r.push_back(RESP_SLVERR);
            end
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clock);
        wr_en = 1'b0;
        if (in_store(a)) mem_m[widx(a)] = d;
    endtask

    // Present a read address and wait (bounded) until the handshake edge is next.
    task automatic issue_ar(input logic [31:0] a, input logic [IDW-1:0] id, input logic [7:0] len,
                            input logic [1:0] bst, input logic [2:0] sz, output int waited);
        model_txn(a, id, len, bst, sz);
        ar_valid = 1'b1;
        ar_addr  = a;
        ar_id    = id;
        ar_len   = len;
        ar_burst = bst;
        ar_size  = sz;
        waited   = 0;
        while (ar_ready !== 1'b1 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (ar_ready !== 1'b1) chk("ar_timeout", 32'(ar_ready), 32'd1);
    endtask

    // Consume the burst, checking every presented beat; optionally keep the next
    // request pending and poke the word under the first beat.
    task automatic serve_r(input int rdy_pct, input bit hold_ar, input bit poke, input bit poke_rdy);
        int lat, i, guard, first_later;
        bit rdy, poked;
        logic [31:0] nd;
        @(negedge clock);
        if (hold_ar) begin
            ar_addr  = nxt_addr;
            ar_id    = nxt_id;
            ar_len   = nxt_len;
            ar_burst = nxt_burst;
            ar_size  = nxt_size;
        end else begin
            ar_valid = 1'b0;
        end
        lat = 1;
        while (r_valid !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT + 1));
        if (r_valid !== 1'b1) return;
        i = 0;
        guard = 0;
        poked = 1'b0;
        while (i <= int'(exp_len) && guard < 2000) begin
            guard++;
            chk("r_valid", 32'(r_valid), 32'd1);
            chk("r_data", r_data, exp_d[i]);
            chk("r_resp", 32'(r_resp), 32'(exp_r[i]));
            chk("r_last", 32'(r_last), 32'(i == int'(exp_len)));
            chk("r_id", 32'(r_id), 32'(exp_id));
            chk("ar_ready_busy", 32'(ar_ready), 32'd0);
            rdy = (int'($urandom_range(0, 99)) < rdy_pct);
            if (poke && i == 0 && !poked) begin
                poked   = 1'b1;
                rdy     = poke_rdy;
                nd      = $urandom;
                wr_en   = 1'b1;
                wr_addr = exp_a[0];
                wr_data = nd;
                if (in_store(exp_a[0])) begin
                    mem_m[widx(exp_a[0])] = nd;
                    first_later = rdy ? 2 : 1;
                    for (int j = first_later; j <= int'(exp_len); j++) begin
                        if (exp_r[j] == RESP_OKAY && widx(exp_a[j]) == widx(exp_a[0]))
                            exp_d[j] = nd;
                    end
                end
            end
            r_ready = rdy;
            @(negedge clock);
            wr_en = 1'b0;
            if (rdy) i++;
        end
        r_ready = 1'b0;
        chk("end_r_valid", 32'(r_valid), 32'd0);
        chk("end_ar_ready", 32'(ar_ready), 32'd1);
    endtask

    task automatic txn(input logic [31:0] a, input logic [IDW-1:0] id, input logic [7:0] len,
                       input logic [1:0] bst, input logic [2:0] sz, input int rdy_pct);
        int w;
        issue_ar(a, id, len, bst, sz, w);
        serve_r(rdy_pct, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, g, sel;
        logic [31:0] a;
        logic [7:0]  len;
        logic [1:0]  bst;
        logic [2:0]  sz;

        repeat (3) @(negedge clock);
        chk("rst_ar_ready", 32'(ar_ready), 32'd0);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_r_data", r_data, 32'd0);
        chk("rst_r_last", 32'(r_last), 32'd0);
        chk("rst_r_resp", 32'(r_resp), 32'd0);
        chk("rst_r_id", 32'(r_id), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_ar_ready", 32'(ar_ready), 32'd1);

        for (int i = 0; i < DEPTH; i++) preload(BASE + 32'(4 * i), $urandom);

        // Single beat.
        preload(32'h8000_0010, 32'hDEAD_BEEF);
        txn(32'h8000_0010, 4'd3, 8'd0, BURST_INCR, 3'd2, 100);

        // INCR 4 beats with backpressure.
        for (int i = 0; i < 4; i++) preload(32'h8000_0100 + 32'(4 * i), 32'(i + 1));
        txn(32'h8000_0100, 4'd1, 8'd3, BURST_INCR, 3'd2, 50);

        // WRAP 4 beats starting mid-span.
        for (int i = 0; i < 4; i++) preload(32'h8000_0100 + 32'(4 * i), 32'hA + 32'(i));
        txn(32'h8000_0108, 4'd2, 8'd3, BURST_WRAP, 3'd2, 70);

        // Error and boundary cases.
        txn(32'h7FFF_FFFC, 4'd4, 8'd1, BURST_INCR, 3'd2, 100);
        txn(32'h8000_0020, 4'd5, 8'd0, BURST_INCR, 3'd1, 100);
        txn(32'h8000_0100, 4'd6, 8'd2, BURST_WRAP, 3'd2, 100);
        txn(32'h8000_0100, 4'd7, 8'd1, 2'd3, 3'd2, 100);
        txn(32'h8000_3FF8, 4'd8, 8'd3, BURST_INCR, 3'd2, 100);
        txn(32'hFFFF_FFF8, 4'd9, 8'd3, BURST_INCR, 3'd2, 100);

        // Out-of-range preloads must not alias into the store.
        preload(32'h7FFF_FFF0, 32'h1111_1111);
        preload(32'h8000_4000, 32'h2222_2222);
        txn(32'h8000_3FF0, 4'd10, 8'd0, BURST_INCR, 3'd2, 100);
        txn(32'h8000_0000, 4'd11, 8'd0, BURST_INCR, 3'd2, 100);

        // Reset in the middle of an 8-beat burst.
        issue_ar(32'h8000_0200, 4'd5, 8'd7, BURST_INCR, 3'd2, w);
        @(negedge clock);
        ar_valid = 1'b0;
        g = 0;
        while (r_valid !== 1'b1 && g < 40) begin
            @(negedge clock);
            g++;
        end
        r_ready = 1'b1;
        @(negedge clock);
        chk("mid_beat1", r_data, exp_d[1]);
        @(negedge clock);
        chk("mid_beat2", r_data, exp_d[2]);
        reset   = 1'b0;
        r_ready = 1'b0;
        @(negedge clock);
        chk("mid_rst_r_valid", 32'(r_valid), 32'd0);
        chk("mid_rst_ar_ready", 32'(ar_ready), 32'd0);
        chk("mid_rst_r_data", r_data, 32'd0);
        chk("mid_rst_r_last", 32'(r_last), 32'd0);
        chk("mid_rst_r_id", 32'(r_id), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("post_rst_r_valid", 32'(r_valid), 32'd0);
            chk("post_rst_ar_ready", 32'(ar_ready), 32'd1);
        end
        txn(32'h8000_0300, 4'd12, 8'd3, BURST_INCR, 3'd2, 100);

        // Next request held during the burst, word rewritten under backpressure.
        nxt_addr  = 32'h8000_0404;
        nxt_id    = 4'd14;
        nxt_len   = 8'd7;
        nxt_burst = BURST_WRAP;
        nxt_size  = 3'd2;
        issue_ar(32'h8000_0300, 4'd13, 8'd3, BURST_INCR, 3'd2, w);
        serve_r(60, 1'b1, 1'b1, 1'b0);
        issue_ar(nxt_addr, nxt_id, nxt_len, nxt_burst, nxt_size, w);
        chk("overlap_accept_wait", 32'(w), 32'd0);
        serve_r(100, 1'b0, 1'b0, 1'b0);

        // FIXED burst with a write landing on the same edge as the next beat load.
        issue_ar(32'h8000_0500, 4'd15, 8'd3, BURST_FIXED, 3'd2, w);
        serve_r(100, 1'b0, 1'b1, 1'b1);

        // Randomized bursts.
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4) bst = BURST_INCR;
            else if (sel < 7) bst = BURST_WRAP;
            else if (sel < 9) bst = BURST_FIXED;
            else bst = 2'd3;
            if (bst == BURST_WRAP) begin
                sel = int'($urandom_range(0, 5));
                len = (sel == 0) ? 8'd1 : (sel == 1) ? 8'd3 : (sel == 2) ? 8'd7 :
                      (sel == 3) ? 8'd15 : 8'($urandom_range(0, 16));
            end else begin
                len = 8'($urandom_range(0, 15));
            end
            sel = int'($urandom_range(0, 9));
            if (sel == 0) a = BASE + 32'(DEPTH * 4) - 32'd8;
            else if (sel == 1) a = BASE - 32'd8;
            else a = BASE + {18'd0, 12'($urandom_range(0, DEPTH - 1)), 2'b00};
            sz = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
            issue_ar(a, 4'($urandom_range(0, 15)), len, bst, sz, w);
            serve_r(int'($urandom_range(30, 100)), 1'b0, (t % 5) == 0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
